// File: rtl/pre_add.sv
// pre_add: TX-side preamble inserter.
// Prepends the start/preamble/SFD word to every frame, delays the frame by one
// word through a hold register, forces an inter-frame gap after each Eof, and
// closes frames that underrun or are cut by an early Sof with an Err-marked Eof.
module pre_add #(
    parameter logic [63:0] PRE_NUM   = 64'hfb555555555555d5,
    parameter int          IFG_WORDS = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        TxDv,
    input  logic [63:0] TxD,
    input  logic        TxSof,
    input  logic        TxEof,
    input  logic [2:0]  TxMod,
    output logic        TxRdy,
    output logic        PreTxdv,
    output logic [63:0] PreTxd,
    output logic        PreTxSof,
    output logic        PreTxEof,
    output logic [2:0]  PreTxMod,
    output logic        PreTxErr
);

    localparam logic [3:0] IFG_CNT = 4'(IFG_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_IFG  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;

    logic        r_hold_vld, w_hold_vld;
    logic [63:0] r_hold_d,   w_hold_d;
    logic        r_hold_eof, w_hold_eof;
    logic [2:0]  r_hold_mod, w_hold_mod;
    logic [3:0]  r_cnt,      w_cnt;

    logic        r_dv,  w_dv;
    logic [63:0] r_d,   w_d;
    logic        r_sof, w_sof;
    logic        r_eof, w_eof;
    logic [2:0]  r_mod, w_mod;
    logic        r_err, w_err;

    logic        w_acc;

    // Ready is a pure state decode so the encoder-side source sees no
    // combinational path from its own valid back to ready.
    assign TxRdy = ~Reset & ((r_state == ST_IDLE) |
                             ((r_state == ST_DATA) & ~r_hold_eof));
    assign w_acc = TxDv & TxRdy;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode; any DATA cycle that is not a plain continuation closes the frame
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_acc && TxSof) w_state_nxt = ST_DATA;
            ST_DATA: if (!r_hold_vld || r_hold_eof || !TxDv || TxSof) w_state_nxt = ST_IFG;
            ST_IFG:  if (r_cnt <= 4'd1) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next output word, hold register and gap counter
    always_comb begin
        w_dv       = 1'b0;
        w_d        = '0;
        w_sof      = 1'b0;
        w_eof      = 1'b0;
        w_mod      = '0;
        w_err      = 1'b0;
        w_hold_vld = r_hold_vld;
        w_hold_d   = r_hold_d;
        w_hold_eof = r_hold_eof;
        w_hold_mod = r_hold_mod;
        w_cnt      = r_cnt;
        case (r_state)
            ST_IDLE: begin
                // Non-Sof words accepted here are dropped (tail of an aborted frame)
                if (w_acc && TxSof) begin
                    w_dv       = 1'b1;
                    w_sof      = 1'b1;
                    w_d        = PRE_NUM;
                    w_hold_vld = 1'b1;
                    w_hold_d   = TxD;
                    w_hold_eof = TxEof;
                    w_hold_mod = TxEof ? TxMod : 3'd0;
                end
            end
            ST_DATA: begin
                if (r_hold_vld) begin
                    w_dv = 1'b1;
                    w_d  = r_hold_d;
                    if (r_hold_eof) begin
                        w_eof = 1'b1;
                        w_mod = r_hold_mod;
                    end else if (TxDv && !TxSof) begin
                        w_hold_d   = TxD;
                        w_hold_eof = TxEof;
                        w_hold_mod = TxEof ? TxMod : 3'd0;
                    end else begin
                        // Underrun or early Sof: close with an errored Eof
                        w_eof = 1'b1;
                        w_err = 1'b1;
                    end
                end
                if (!r_hold_vld || r_hold_eof || !TxDv || TxSof) begin
                    w_hold_vld = 1'b0;
                    w_hold_d   = '0;
                    w_hold_eof = 1'b0;
                    w_hold_mod = '0;
                    w_cnt      = IFG_CNT;
                end
            end
            ST_IFG: begin
                if (r_cnt != 4'd0) w_cnt = r_cnt - 4'd1;
            end
            default: ;
        endcase
    end

    // Registered outputs, hold register and counter
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_dv       <= 1'b0;
            r_d        <= '0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_mod      <= '0;
            r_err      <= 1'b0;
            r_hold_vld <= 1'b0;
            r_hold_d   <= '0;
            r_hold_eof <= 1'b0;
            r_hold_mod <= '0;
            r_cnt      <= '0;
        end else begin
            r_dv       <= w_dv;
            r_d        <= w_d;
            r_sof      <= w_sof;
            r_eof      <= w_eof;
            r_mod      <= w_mod;
            r_err      <= w_err;
            r_hold_vld <= w_hold_vld;
            r_hold_d   <= w_hold_d;
            r_hold_eof <= w_hold_eof;
            r_hold_mod <= w_hold_mod;
            r_cnt      <= w_cnt;
        end
    end

    assign PreTxdv  = r_dv;
    assign PreTxd   = r_d;
    assign PreTxSof = r_sof;
    assign PreTxEof = r_eof;
    assign PreTxMod = r_mod;
    assign PreTxErr = r_err;

endmodule

// File: tb/tb_pre_add.sv
// Bench for pre_add: three instances (IFG 2, 1, 5), randomized frame data,
// expected streams built from the frame timing rules.
module tb_pre_add;

    localparam logic [63:0] PRE = 64'hfb555555555555d5;
    localparam int ND = 3;

    typedef struct packed {
        logic        dv;
        logic        sof;
        logic        eof;
        logic        err;
        logic [2:0]  mod;
        logic [63:0] d;
    } ow_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        dv [ND];
    logic [63:0] d  [ND];
    logic        sof[ND];
    logic        eof[ND];
    logic [2:0]  mod[ND];
    logic        rdy [ND];
    logic        odv [ND];
    logic [63:0] od  [ND];
    logic        osof[ND];
    logic        oeof[ND];
    logic [2:0]  omod[ND];
    logic        oerr[ND];

    int pass_cnt = 0;
    int total    = 0;

    always #5 Clk = ~Clk;

    pre_add #(.PRE_NUM(PRE), .IFG_WORDS(2)) u0 (
        .Clk(Clk), .Reset(Reset), .TxDv(dv[0]), .TxD(d[0]), .TxSof(sof[0]), .TxEof(eof[0]),
        .TxMod(mod[0]), .TxRdy(rdy[0]), .PreTxdv(odv[0]), .PreTxd(od[0]), .PreTxSof(osof[0]),
        .PreTxEof(oeof[0]), .PreTxMod(omod[0]), .PreTxErr(oerr[0]));
    pre_add #(.PRE_NUM(PRE), .IFG_WORDS(1)) u1 (
        .Clk(Clk), .Reset(Reset), .TxDv(dv[1]), .TxD(d[1]), .TxSof(sof[1]), .TxEof(eof[1]),
        .TxMod(mod[1]), .TxRdy(rdy[1]), .PreTxdv(odv[1]), .PreTxd(od[1]), .PreTxSof(osof[1]),
        .PreTxEof(oeof[1]), .PreTxMod(omod[1]), .PreTxErr(oerr[1]));
    pre_add #(.PRE_NUM(PRE), .IFG_WORDS(5)) u2 (
        .Clk(Clk), .Reset(Reset), .TxDv(dv[2]), .TxD(d[2]), .TxSof(sof[2]), .TxEof(eof[2]),
        .TxMod(mod[2]), .TxRdy(rdy[2]), .PreTxdv(odv[2]), .PreTxd(od[2]), .PreTxSof(osof[2]),
        .PreTxEof(oeof[2]), .PreTxMod(omod[2]), .PreTxErr(oerr[2]));

    function automatic int ifg_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 5;
    endfunction

    function automatic ow_t cap(input int i);
        return {odv[i], osof[i], oeof[i], oerr[i], omod[i], od[i]};
    endfunction

    function automatic ow_t mk(input logic v, input logic s, input logic e, input logic r,
                               input logic [2:0] m, input logic [63:0] dd);
        return {v, s, e, r, m, dd};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic put(input int i, input logic v, input logic s, input logic e,
                       input logic [2:0] m, input logic [63:0] dd);
        dv[i] = v; sof[i] = s; eof[i] = e; mod[i] = m; d[i] = dd;
    endtask

    task automatic test_reset();
        for (int i = 0; i < ND; i++) put(i, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        Reset = 1'b1;
        repeat (3) tick();
        put(0, 1'b1, 1'b1, 1'b0, 3'd0, rnd64());
        tick();
        total++;
        if (cap(0) !== '0) $display("FAIL reset_outputs got %h want 0", cap(0));
        else pass_cnt++;
        for (int i = 0; i < ND; i++) begin
            total++;
            if (rdy[i] !== 1'b0) $display("FAIL reset_rdy%0d got %b want 0", i, rdy[i]);
            else pass_cnt++;
        end
        put(0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        Reset = 1'b0;
        #1;
        for (int i = 0; i < ND; i++) begin
            total++;
            if (rdy[i] !== 1'b1) $display("FAIL release_rdy%0d got %b want 1", i, rdy[i]);
            else pass_cnt++;
        end
        tick();
        total++;
        if (cap(0) !== '0) $display("FAIL release_idle got %h want 0", cap(0));
        else pass_cnt++;
    endtask

    // Frame of k words on u0 with TxDv held high; expected stream from the
    // Sof edge: preamble, k data words, then idle; ready low for 1+IFG cycles.
    task automatic test_frame(input int k, input logic [2:0] m, input string nm);
        logic [63:0] w[$];
        ow_t         got[$];
        logic        rq[$];
        ow_t         exp;
        logic        er;
        int          ifg = ifg_of(0);
        int          zeros = 0;
        for (int j = 0; j < k; j++) w.push_back(rnd64());
        total++;
        if (rdy[0] !== 1'b1) $display("FAIL %s rdy_before_sof got %b want 1", nm, rdy[0]);
        else pass_cnt++;
        for (int j = 0; j < k; j++) begin
            put(0, 1'b1, j == 0, j == k - 1, (j == k - 1) ? m : 3'($urandom), w[j]);
            tick();
            got.push_back(cap(0));
            rq.push_back(rdy[0]);
        end
        put(0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        repeat (ifg + 3) begin
            tick();
            got.push_back(cap(0));
            rq.push_back(rdy[0]);
        end
        foreach (got[j]) begin
            if (j == 0)      exp = mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, PRE);
            else if (j <= k) exp = mk(1'b1, 1'b0, j == k, 1'b0, (j == k) ? m : 3'd0, w[j-1]);
            else             exp = '0;
            er = !(j >= k - 1 && j <= k - 1 + ifg);
            total++;
            if (got[j] !== exp) $display("FAIL %s word%0d got %h want %h", nm, j, got[j], exp);
            else pass_cnt++;
            total++;
            if (rq[j] !== er) $display("FAIL %s rdy%0d got %b want %b", nm, j, rq[j], er);
            else pass_cnt++;
            if (rq[j] === 1'b0) zeros++;
        end
        total++;
        if (zeros != 1 + ifg) $display("FAIL %s rdy_low_cycles got %0d want %0d", nm, zeros, 1 + ifg);
        else pass_cnt++;
    endtask

    // Frame D0, D1 then either an idle cycle (underrun) or a new Sof word;
    // D1 must close with Eof+Err and everything after it must stay idle.
    task automatic test_abort(input logic via_sof, input string nm);
        logic [63:0] w[5];
        ow_t         got[$];
        ow_t         exp;
        logic        r;
        logic        rafter;
        for (int j = 0; j < 5; j++) w[j] = rnd64();
        put(0, 1'b1, 1'b1, 1'b0, 3'd2, w[0]); tick(); got.push_back(cap(0));
        put(0, 1'b1, 1'b0, 1'b0, 3'd4, w[1]); tick(); got.push_back(cap(0));
        if (via_sof) put(0, 1'b1, 1'b1, 1'b0, 3'd7, w[2]);
        else         put(0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        tick(); got.push_back(cap(0));
        rafter = rdy[0];
        for (int j = via_sof ? 3 : 2; j < 5; j++) begin
            put(0, 1'b1, 1'b0, j == 4, 3'd6, w[j]);
            r = 1'b0;
            for (int n = 0; n < 20; n++) begin
                r = rdy[0];
                tick();
                got.push_back(cap(0));
                if (r) break;
            end
            total++;
            if (r !== 1'b1) $display("FAIL %s tail%0d_accept got %b want 1", nm, j, r);
            else pass_cnt++;
        end
        put(0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        repeat (3) begin tick(); got.push_back(cap(0)); end
        total++;
        if (rafter !== 1'b0) $display("FAIL %s rdy_after_err got %b want 0", nm, rafter);
        else pass_cnt++;
        foreach (got[j]) begin
            if (j == 0)      exp = mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, PRE);
            else if (j == 1) exp = mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, w[0]);
            else if (j == 2) exp = mk(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, w[1]);
            else             exp = '0;
            total++;
            if (got[j] !== exp) $display("FAIL %s word%0d got %h want %h", nm, j, got[j], exp);
            else pass_cnt++;
        end
    endtask

    // Frames offered continuously; output checked against a data scoreboard
    // and each Eof-to-preamble gap measured against the instance's IFG.
    task automatic test_back_to_back(input int i);
        ow_t         inq[$];
        ow_t         expq[$];
        ow_t         o;
        ow_t         e;
        logic [63:0] w;
        logic [2:0]  m;
        logic        r;
        int          k;
        int          nf = 6;
        int          ifg = ifg_of(i);
        int          cyc = 0;
        int          last_eof = -1;
        int          last_v = -1;
        int          seen = 0;
        int          gaps = 0;
        int          nexp;
        int          extra = 0;
        for (int f = 0; f < nf; f++) begin
            k = $urandom_range(1, 5);
            m = 3'($urandom);
            expq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, PRE));
            for (int j = 0; j < k; j++) begin
                w = rnd64();
                inq.push_back(mk(1'b1, j == 0, j == k - 1, 1'b0, (j == k - 1) ? m : 3'($urandom), w));
                expq.push_back(mk(1'b1, 1'b0, j == k - 1, 1'b0, (j == k - 1) ? m : 3'd0, w));
            end
        end
        nexp = expq.size();
        while (seen < nexp && cyc < 1000) begin
            if (inq.size() > 0) put(i, 1'b1, inq[0].sof, inq[0].eof, inq[0].mod, inq[0].d);
            else                put(i, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
            r = rdy[i];
            tick();
            cyc++;
            if (r && inq.size() > 0) void'(inq.pop_front());
            o = cap(i);
            if (o.dv) begin
                seen++;
                e = expq.pop_front();
                total++;
                if (o !== e) $display("FAIL b2b_ifg%0d word%0d got %h want %h", ifg, seen, o, e);
                else pass_cnt++;
                if (o.sof) begin
                    if (last_eof >= 0) begin
                        gaps++;
                        total++;
                        if (cyc - last_eof - 1 != ifg)
                            $display("FAIL b2b_ifg%0d gap got %0d want %0d", ifg, cyc - last_eof - 1, ifg);
                        else pass_cnt++;
                    end
                end else begin
                    total++;
                    if (cyc != last_v + 1)
                        $display("FAIL b2b_ifg%0d contiguous got %0d want %0d", ifg, cyc, last_v + 1);
                    else pass_cnt++;
                end
                if (o.eof) last_eof = cyc;
                last_v = cyc;
            end
        end
        put(i, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        repeat (ifg + 3) begin
            tick();
            if (odv[i] !== 1'b0) extra++;
        end
        total++;
        if (seen != nexp) $display("FAIL b2b_ifg%0d words_seen got %0d want %0d", ifg, seen, nexp);
        else pass_cnt++;
        total++;
        if (gaps != nf - 1) $display("FAIL b2b_ifg%0d gaps got %0d want %0d", ifg, gaps, nf - 1);
        else pass_cnt++;
        total++;
        if (extra != 0) $display("FAIL b2b_ifg%0d extra_words got %0d want 0", ifg, extra);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        put(0, 1'b1, 1'b1, 1'b0, 3'd0, rnd64()); tick();
        put(0, 1'b1, 1'b0, 1'b0, 3'd0, rnd64()); tick();
        put(0, 1'b1, 1'b0, 1'b0, 3'd0, rnd64());
        #2;
        Reset = 1'b1;
        #1;
        total++;
        if (cap(0) !== '0) $display("FAIL midreset_outputs got %h want 0", cap(0));
        else pass_cnt++;
        total++;
        if (rdy[0] !== 1'b0) $display("FAIL midreset_rdy got %b want 0", rdy[0]);
        else pass_cnt++;
        tick();
        total++;
        if (cap(0) !== '0) $display("FAIL midreset_held got %h want 0", cap(0));
        else pass_cnt++;
        put(0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        Reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            put(0, 1'b1, 1'b0, j == 2, 3'd7, rnd64());
            tick();
            total++;
            if (cap(0) !== '0) $display("FAIL postreset_nonsof%0d got %h want 0", j, cap(0));
            else pass_cnt++;
        end
        put(0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        tick();
        test_frame(3, 3'($urandom), "after_midreset");
    endtask

    initial begin
        test_reset();
        test_frame(4, 3'd5, "frame4");
        test_frame(1, 3'd3, "single");
        repeat (4) test_frame($urandom_range(2, 8), 3'($urandom), "rand_frame");
        test_abort(1'b0, "underrun");
        test_frame($urandom_range(1, 6), 3'($urandom), "after_underrun");
        test_abort(1'b1, "new_sof");
        test_frame($urandom_range(1, 6), 3'($urandom), "after_new_sof");
        test_back_to_back(1);
        test_back_to_back(2);
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/pre_add.md
Name: pre_add

Overview:
Transmit-side counterpart of the receive preamble stripper. It accepts 64-bit framed words (Sof/Eof/Mod) from the MAC TX datapath and prepends the 64-bit start/preamble/SFD word to each frame. It enforces a minimum inter-frame gap and closes frames that are aborted or underrun. It sits between the TX frame source and the XGMII encoder, which consumes one word every Clk with no backpressure.

Parameters:
PRE_NUM, 64'hfb555555555555d5, start/preamble/SFD word emitted ahead of each frame.
IFG_WORDS, 2, number of idle output words forced after each Eof word (legal range 1..15).

Ports:
Clk  in  1  clock.
Reset  in  1  reset. Asynchronous, active-high.
TxDv  in  1  input word valid.
TxD  in  64  input frame data.
TxSof  in  1  first word of frame; qualified by TxDv.
TxEof  in  1  last word of frame; qualified by TxDv.
TxMod  in  3  valid bytes in the Eof word, passed through unchanged.
TxRdy  out  1  block can accept a word; a word is accepted when TxDv&TxRdy.
PreTxdv  out  1  output word valid.
PreTxd  out  64  output data.
PreTxSof  out  1  marks the preamble word.
PreTxEof  out  1  marks the last frame word.
PreTxMod  out  3  TxMod of the Eof word; 0 on all other words.
PreTxErr  out  1  one-cycle pulse on a forced (aborted) Eof word.

Behaviour:
- Reset: the block is asynchronous; Reset is active-high; the clock is Clk. While Reset is asserted, all Pre* outputs are 0, state=IDLE, the hold register is cleared, the IFG counter is 0, and TxRdy=0.
- All Pre* outputs are registered. When PreTxdv=0, PreTxd/Sof/Eof/Mod/Err=0.
- Hold register: HoldVld, HoldD, HoldEof, HoldMod. The frame is delayed by one word through it.
- TxRdy is decoded from state only, with no input-to-output combinational path: TxRdy = ~Reset & ((IDLE) | (DATA & ~HoldEof)).
- States: IDLE, DATA, IFG.
- IDLE:
  - Accepted word with TxSof=1: at that edge, output PRE_NUM with PreTxSof=1, PreTxdv=1 and Mod=0; load hold with the word; go to DATA.
  - Accepted word with TxSof=0: discarded silently.
- DATA, HoldEof=0, each edge:
  - TxDv=1 and TxSof=0: output the hold word (Eof=0, Mod=0) and load hold with the input. If TxEof=1, HoldEof is set (and HoldMod=TxMod); TxRdy then drops the next cycle.
  - TxDv=0 (underrun): output the hold word with PreTxEof=1, PreTxErr=1, Mod=0; go to IFG.
  - TxDv=1 and TxSof=1 (new Sof before Eof): same as underrun. The new Sof word is consumed and dropped; its remaining words are discarded in IDLE.
- DATA, HoldEof=1: output the hold word with PreTxEof=1 and PreTxMod=HoldMod; clear hold; load the counter with IFG_WORDS; go to IFG.
- A single-word frame (TxSof&TxEof) is legal: preamble, then one Eof word.
- IFG: outputs idle; counter decrements each edge; at count 1 go to IDLE.
- Timing: with Sof accepted at edge N on a K-word frame:
  - preamble out at edge N;
  - word i out at edge N+1+i;
  - Eof out at edge N+K.
  - The next Sof can be accepted no earlier than edge N+K+IFG_WORDS+1, which gives exactly IFG_WORDS idle words between the Eof and the next preamble.
- Reset mid-frame: the frame is truncated without an Eof; after release the block is in IDLE and waits for a new Sof.

Test Plan:
- After Reset release, a 4-word frame D0..D3 (Mod=5) with TxDv held high: output is PRE_NUM (Sof=1), D0, D1, D2, D3 (Eof=1, Mod=5) on consecutive cycles; TxRdy=0 for exactly 3 cycles (1 + IFG_WORDS); then 2 idle output words.
- Single-word frame with Sof=Eof=1, Mod=3: output is preamble then that word with Eof=1, Mod=3; Err=0.
- Underrun (TxDv=0 after D1 of a 5-word frame): D0 normal, D1 with Eof=1 and Err=1; the remaining D2..D4 are discarded; the next Sof produces a clean frame.
- New Sof arriving as the 3rd word of a frame: D1 carries Eof=1, Err=1; the new Sof word is dropped; no preamble is emitted until a later Sof.
- Back-to-back frames offered continuously with IFG_WORDS=1, then 5: measured idle-word gaps are 1 and 5; no word is lost or duplicated (compare a scoreboard by data).
- Reset asserted in the middle of a frame: all outputs go to 0 and TxRdy goes to 0 immediately; after release, non-Sof words are ignored and the next Sof frame is correct.
